// File: rtl/umni_pkg.sv
// Shared types and defaults for the humidity accumulator.
package umni_pkg;

    localparam int unsigned DEF_DATA_W  = 7;
    localparam int unsigned DEF_MAX_VAL = 100;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/somador_param.sv
// Parametrised ripple-carry adder: sum = a + b + cin, with carry-out.
module somador_param #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic carry;

    // Bit-serial carry chain, LSB to MSB.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/acumulador_umidade.sv
// Sequential humidity accumulator: sums N_CH saturated readings one per cycle,
// then derives the floor average with a restoring divider sharing one adder.
module acumulador_umidade
    import umni_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MAX_VAL = DEF_MAX_VAL,
    localparam int unsigned SUM_W  = DATA_W + $clog2(N_CH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_CH*DATA_W-1:0] sensor_data,
    output logic                   busy,
    output logic                   done,
    output logic [SUM_W-1:0]       soma,
    output logic [DATA_W-1:0]      media,
    output logic                   erro_faixa
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(SUM_W);

    localparam logic [DATA_W-1:0] MAX_W    = DATA_W'(MAX_VAL);
    localparam logic [SUM_W-1:0]  DIVISOR  = SUM_W'(N_CH);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SUM_W - 1);

    state_t                   state_q;
    logic [N_CH*DATA_W-1:0]   cap_q;   // shifts right so channel idx sits at the bottom
    logic [SUM_W-1:0]         acc_q;
    logic [IDX_W-1:0]         idx_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [SUM_W-1:0]         div_q;   // dividend, consumed MSB first
    logic [SUM_W-1:0]         rem_q;
    logic [DATA_W-1:0]        quo_q;

    logic [DATA_W-1:0]        ch_raw;
    logic [DATA_W-1:0]        ch_sat;
    logic                     ch_over;
    logic [SUM_W-1:0]         rem_shift;
    logic [SUM_W-1:0]         rem_next;
    logic [DATA_W-1:0]        quo_next;
    logic [SUM_W-1:0]         add_a;
    logic [SUM_W-1:0]         add_b;
    logic                     add_cin;
    logic [SUM_W-1:0]         add_sum;
    logic                     add_cout;

    // Shifted-out MSBs are always zero: remainder < N_CH and quotient fits DATA_W.
    logic unused_msbs;
    assign unused_msbs = ^{rem_q[SUM_W-1], quo_q[DATA_W-1]};

    // Saturation, divider step and shared-adder operand selection.
    always_comb begin
        ch_raw    = cap_q[DATA_W-1:0];
        ch_over   = ch_raw > MAX_W;
        ch_sat    = ch_over ? MAX_W : ch_raw;
        rem_shift = {rem_q[SUM_W-2:0], div_q[SUM_W-1]};

        add_a   = acc_q;
        add_b   = {{(SUM_W - DATA_W){1'b0}}, ch_sat};
        add_cin = 1'b0;
        if (state_q == DIV) begin
            // Trial subtraction rem_shift - N_CH; carry-out means no borrow.
            add_a   = rem_shift;
            add_b   = ~DIVISOR;
            add_cin = 1'b1;
        end

        rem_next = add_cout ? add_sum : rem_shift;
        quo_next = {quo_q[DATA_W-2:0], add_cout};
    end

    somador_param #(
        .W (SUM_W)
    ) u_somador (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            soma       <= '0;
            media      <= '0;
            erro_faixa <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cap_q      <= sensor_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        erro_faixa <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q      <= add_sum;
                    erro_faixa <= erro_faixa | ch_over;
                    cap_q      <= cap_q >> DATA_W;
                    idx_q      <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        div_q   <= add_sum;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    div_q <= div_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        soma    <= acc_q;
                        media   <= quo_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
